// File: rtl/parity_unit.sv
// parity_unit: UART parity engine shared by the Tx and Rx paths.
//   Tx: captures P_DATA on Data_Valid && !busy, masks it to the effective
//       character length and registers the parity bit (tx_par_bit/tx_par_vld).
//   Rx: accumulates parity over serial data bits between rx_start and
//       rx_par_en, checks the received parity bit and the bit count, pulses
//       rx_par_done/rx_par_err and keeps a saturating error counter.
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   P_DATA, Data_Valid, busy          Tx word and capture handshake
//   PAR_EN, PAR_MODE, DATA_LEN        runtime parity configuration
//   tx_par_bit, tx_par_vld            Tx parity result
//   rx_start, rx_bit, rx_bit_en, rx_par_en   Rx frame events
//   rx_par_done, rx_par_err           Rx check pulses
//   err_cnt, err_cnt_clr              saturating Rx error counter
module parity_unit #(
    parameter int unsigned DATA_WD    = 8,
    parameter int unsigned ERR_CNT_WD = 8,
    parameter int unsigned LEN_WD     = $clog2(DATA_WD + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WD-1:0]    P_DATA,
    input  logic                  Data_Valid,
    input  logic                  busy,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_MODE,
    input  logic [LEN_WD-1:0]     DATA_LEN,
    output logic                  tx_par_bit,
    output logic                  tx_par_vld,
    input  logic                  rx_start,
    input  logic                  rx_bit,
    input  logic                  rx_bit_en,
    input  logic                  rx_par_en,
    output logic                  rx_par_done,
    output logic                  rx_par_err,
    output logic [ERR_CNT_WD-1:0] err_cnt,
    input  logic                  err_cnt_clr
);

    typedef enum logic [1:0] {T_IDLE, T_CALC, T_HOLD} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACC, R_CHK} rx_state_t;

    // Parity bit for a given data XOR-reduction, enable and mode.
    function automatic logic par_sel(input logic red, input logic en, input logic [1:0] mode);
        logic p;
        case (mode)
            2'b00:   p = red;
            2'b01:   p = ~red;
            2'b10:   p = 1'b1;
            default: p = 1'b0;
        endcase
        return en ? p : 1'b0;
    endfunction

    // Effective character length: 0 or out-of-range selects the full width.
    logic [LEN_WD-1:0]  eff_len_c;
    logic [DATA_WD-1:0] len_mask_c;
    always_comb begin
        eff_len_c = DATA_LEN;
        if (DATA_LEN == '0 || 32'(DATA_LEN) > DATA_WD) begin
            eff_len_c = LEN_WD'(DATA_WD);
        end
        len_mask_c = '0;
        for (int unsigned i = 0; i < DATA_WD; i++) begin
            len_mask_c[i] = (i < 32'(eff_len_c));
        end
    end

    // ---------------- Tx path ----------------
    tx_state_t          tx_state, tx_state_nxt;
    logic [DATA_WD-1:0] tx_data, tx_data_nxt;
    logic               tx_en, tx_en_nxt;
    logic [1:0]         tx_mode, tx_mode_nxt;
    logic               tx_bit_nxt, tx_vld_nxt;
    logic               tx_capture_c;

    assign tx_capture_c = Data_Valid && !busy;

    // Tx next-state and output logic.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_data_nxt  = tx_data;
        tx_en_nxt    = tx_en;
        tx_mode_nxt  = tx_mode;
        tx_bit_nxt   = tx_par_bit;
        tx_vld_nxt   = 1'b0;
        case (tx_state)
            T_IDLE: ;
            T_CALC: begin
                tx_bit_nxt   = par_sel(^tx_data, tx_en, tx_mode);
                tx_state_nxt = T_HOLD;
            end
            T_HOLD:  tx_vld_nxt = 1'b1;
            default: tx_state_nxt = T_IDLE;
        endcase
        // A capture from any state restarts the calculation and drops valid.
        if (tx_capture_c) begin
            tx_data_nxt  = P_DATA & len_mask_c;
            tx_en_nxt    = PAR_EN;
            tx_mode_nxt  = PAR_MODE;
            tx_state_nxt = T_CALC;
            tx_vld_nxt   = 1'b0;
        end
    end

    // Tx state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_state   <= T_IDLE;
            tx_data    <= '0;
            tx_en      <= 1'b0;
            tx_mode    <= 2'b00;
            tx_par_bit <= 1'b0;
            tx_par_vld <= 1'b0;
        end else begin
            tx_state   <= tx_state_nxt;
            tx_data    <= tx_data_nxt;
            tx_en      <= tx_en_nxt;
            tx_mode    <= tx_mode_nxt;
            tx_par_bit <= tx_bit_nxt;
            tx_par_vld <= tx_vld_nxt;
        end
    end

    // ---------------- Rx path ----------------
    rx_state_t          rx_state, rx_state_nxt;
    logic               rx_cfg_en, rx_cfg_en_nxt;
    logic [1:0]         rx_cfg_mode, rx_cfg_mode_nxt;
    logic [LEN_WD-1:0]  rx_len, rx_len_nxt;
    logic               rx_acc, rx_acc_nxt;
    logic [LEN_WD-1:0]  rx_cnt, rx_cnt_nxt;
    logic               rx_ovr, rx_ovr_nxt;
    logic               rx_chk_err, rx_chk_err_nxt;
    logic               rx_done_nxt, rx_err_nxt;
    logic [ERR_CNT_WD-1:0] err_cnt_nxt;

    // Rx next-state and output logic; rx_start has priority over bit events.
    always_comb begin
        rx_state_nxt    = rx_state;
        rx_cfg_en_nxt   = rx_cfg_en;
        rx_cfg_mode_nxt = rx_cfg_mode;
        rx_len_nxt      = rx_len;
        rx_acc_nxt      = rx_acc;
        rx_cnt_nxt      = rx_cnt;
        rx_ovr_nxt      = rx_ovr;
        rx_chk_err_nxt  = rx_chk_err;
        rx_done_nxt     = 1'b0;
        rx_err_nxt      = 1'b0;
        case (rx_state)
            R_IDLE: ;
            R_ACC: begin
                if (!rx_start && rx_par_en) begin
                    rx_chk_err_nxt = (rx_cfg_en && rx_bit != par_sel(rx_acc, rx_cfg_en, rx_cfg_mode))
                                     || rx_cnt != rx_len || rx_ovr;
                    rx_state_nxt   = R_CHK;
                end else if (!rx_start && rx_bit_en) begin
                    if (rx_cnt < rx_len) begin
                        rx_acc_nxt = rx_acc ^ rx_bit;
                        rx_cnt_nxt = rx_cnt + LEN_WD'(1);
                    end else begin
                        rx_ovr_nxt = 1'b1;
                    end
                end
            end
            R_CHK: begin
                rx_done_nxt  = 1'b1;
                rx_err_nxt   = rx_chk_err;
                rx_state_nxt = R_IDLE;
            end
            default: rx_state_nxt = R_IDLE;
        endcase
        if (rx_start) begin
            rx_state_nxt    = R_ACC;
            rx_cfg_en_nxt   = PAR_EN;
            rx_cfg_mode_nxt = PAR_MODE;
            rx_len_nxt      = eff_len_c;
            rx_acc_nxt      = 1'b0;
            rx_cnt_nxt      = '0;
            rx_ovr_nxt      = 1'b0;
        end
    end

    // Saturating error counter; clear wins over increment.
    always_comb begin
        err_cnt_nxt = err_cnt;
        if (err_cnt_clr) begin
            err_cnt_nxt = '0;
        end else if (rx_par_err && err_cnt != '1) begin
            err_cnt_nxt = err_cnt + ERR_CNT_WD'(1);
        end
    end

    // Rx state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_state    <= R_IDLE;
            rx_cfg_en   <= 1'b0;
            rx_cfg_mode <= 2'b00;
            rx_len      <= '0;
            rx_acc      <= 1'b0;
            rx_cnt      <= '0;
            rx_ovr      <= 1'b0;
            rx_chk_err  <= 1'b0;
            rx_par_done <= 1'b0;
            rx_par_err  <= 1'b0;
            err_cnt     <= '0;
        end else begin
            rx_state    <= rx_state_nxt;
            rx_cfg_en   <= rx_cfg_en_nxt;
            rx_cfg_mode <= rx_cfg_mode_nxt;
            rx_len      <= rx_len_nxt;
            rx_acc      <= rx_acc_nxt;
            rx_cnt      <= rx_cnt_nxt;
            rx_ovr      <= rx_ovr_nxt;
            rx_chk_err  <= rx_chk_err_nxt;
            rx_par_done <= rx_done_nxt;
            rx_par_err  <= rx_err_nxt;
            err_cnt     <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_parity_unit.sv
// tb_parity_unit: directed self-checking bench for parity_unit
// (DATA_WD=8, ERR_CNT_WD=2 so counter saturation is reachable).
module tb_parity_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid, busy, PAR_EN;
    logic [1:0] PAR_MODE;
    logic [3:0] DATA_LEN;
    logic       tx_par_bit, tx_par_vld;
    logic       rx_start, rx_bit, rx_bit_en, rx_par_en;
    logic       rx_par_done, rx_par_err;
    logic [1:0] err_cnt;
    logic       err_cnt_clr;

    int n_assert = 0;
    int n_fail   = 0;

    parity_unit #(.DATA_WD(8), .ERR_CNT_WD(2)) dut (
        .CLK(CLK), .RST(RST),
        .P_DATA(P_DATA), .Data_Valid(Data_Valid), .busy(busy),
        .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .DATA_LEN(DATA_LEN),
        .tx_par_bit(tx_par_bit), .tx_par_vld(tx_par_vld),
        .rx_start(rx_start), .rx_bit(rx_bit), .rx_bit_en(rx_bit_en), .rx_par_en(rx_par_en),
        .rx_par_done(rx_par_done), .rx_par_err(rx_par_err),
        .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Capture one Tx word (one Data_Valid cycle), leaving the capture edge just passed.
    task automatic tx_capture(input logic [7:0] d, input logic [3:0] len, input logic en, input logic [1:0] mode);
        P_DATA = d; DATA_LEN = len; PAR_EN = en; PAR_MODE = mode;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
    endtask

    // Send an Rx frame: rx_start, n data bits LSB first, then the parity bit.
    // Returns just after the rx_par_en edge.
    task automatic rx_frame(input logic [15:0] bits, input int n, input logic pbit);
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_bit_en = 1'b1; rx_bit = bits[i];
            tick();
        end
        rx_bit_en = 1'b0;
        rx_par_en = 1'b1; rx_bit = pbit;
        tick();
        rx_par_en = 1'b0; rx_bit = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        P_DATA = '0; Data_Valid = 0; busy = 0; PAR_EN = 0; PAR_MODE = 0; DATA_LEN = 0;
        rx_start = 0; rx_bit = 0; rx_bit_en = 0; rx_par_en = 0; err_cnt_clr = 0;
        tick(); tick();
        n_assert++;
        if ({tx_par_bit, tx_par_vld, rx_par_done, rx_par_err, err_cnt} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {tx_par_bit, tx_par_vld, rx_par_done, rx_par_err, err_cnt});
        end
        RST = 1'b1;
        tick();
        // busy blocks capture
        P_DATA = 8'h01; DATA_LEN = 4'd8; PAR_EN = 1; PAR_MODE = 2'b00;
        busy = 1'b1; Data_Valid = 1'b1;
        tick(); tick(); tick();
        busy = 1'b0; Data_Valid = 1'b0;
        n_assert++;
        if (tx_par_vld !== 1'b0 || tx_par_bit !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_no_capture: got vld=%b bit=%b expected vld=0 bit=0", tx_par_vld, tx_par_bit);
        end
    endtask

    task automatic test_tx_even_odd();
        tx_capture(8'hA5, 4'd8, 1'b1, 2'b00);
        n_assert++;
        if (tx_par_vld !== 1'b0) begin
            n_fail++; $display("FAIL tx_latency_early: got vld=%b expected 0", tx_par_vld);
        end
        tick(); tick();
        n_assert++;
        if (tx_par_vld !== 1'b1 || tx_par_bit !== 1'b0) begin
            n_fail++; $display("FAIL tx_even_A5: got vld=%b bit=%b expected vld=1 bit=0", tx_par_vld, tx_par_bit);
        end
        tx_capture(8'hA5, 4'd8, 1'b1, 2'b01);
        n_assert++;
        if (tx_par_vld !== 1'b0) begin
            n_fail++; $display("FAIL tx_recapture_drop: got vld=%b expected 0", tx_par_vld);
        end
        tick(); tick();
        n_assert++;
        if (tx_par_vld !== 1'b1 || tx_par_bit !== 1'b1) begin
            n_fail++; $display("FAIL tx_odd_A5: got vld=%b bit=%b expected vld=1 bit=1", tx_par_vld, tx_par_bit);
        end
    endtask

    task automatic test_tx_len_busy();
        tx_capture(8'hA5, 4'd7, 1'b1, 2'b00);
        // inputs change after capture must not matter
        PAR_MODE = 2'b01; P_DATA = 8'hFF; DATA_LEN = 4'd8; PAR_EN = 1'b0;
        tick(); tick();
        n_assert++;
        if (tx_par_vld !== 1'b1 || tx_par_bit !== 1'b1) begin
            n_fail++; $display("FAIL tx_len7_masked: got vld=%b bit=%b expected vld=1 bit=1", tx_par_vld, tx_par_bit);
        end
        // busy while holding: no recapture, result kept
        P_DATA = 8'h00; PAR_EN = 1'b1; PAR_MODE = 2'b00;
        busy = 1'b1; Data_Valid = 1'b1;
        tick(); tick(); tick();
        busy = 1'b0; Data_Valid = 1'b0;
        n_assert++;
        if (tx_par_vld !== 1'b1 || tx_par_bit !== 1'b1) begin
            n_fail++; $display("FAIL tx_busy_hold: got vld=%b bit=%b expected vld=1 bit=1", tx_par_vld, tx_par_bit);
        end
    endtask

    task automatic test_tx_modes();
        tx_capture(8'h00, 4'd8, 1'b1, 2'b10);
        tick(); tick();
        n_assert++;
        if (tx_par_bit !== 1'b1) begin
            n_fail++; $display("FAIL tx_mark: got %b expected 1", tx_par_bit);
        end
        tx_capture(8'h00, 4'd8, 1'b1, 2'b11);
        tick(); tick();
        n_assert++;
        if (tx_par_bit !== 1'b0) begin
            n_fail++; $display("FAIL tx_space: got %b expected 0", tx_par_bit);
        end
        tx_capture(8'h00, 4'd8, 1'b1, 2'b10);
        tick(); tick();
        tx_capture(8'h00, 4'd8, 1'b0, 2'b10);
        tick(); tick();
        n_assert++;
        if (tx_par_bit !== 1'b0 || tx_par_vld !== 1'b1) begin
            n_fail++; $display("FAIL tx_par_disabled: got bit=%b vld=%b expected bit=0 vld=1", tx_par_bit, tx_par_vld);
        end
        tx_capture(8'h80, 4'd0, 1'b1, 2'b00);
        tick(); tick();
        n_assert++;
        if (tx_par_bit !== 1'b1) begin
            n_fail++; $display("FAIL tx_len0_full: got %b expected 1", tx_par_bit);
        end
        tx_capture(8'h80, 4'd7, 1'b1, 2'b00);
        tick(); tick();
        n_assert++;
        if (tx_par_bit !== 1'b0) begin
            n_fail++; $display("FAIL tx_len7_msb_masked: got %b expected 0", tx_par_bit);
        end
        tx_capture(8'h80, 4'd15, 1'b1, 2'b00);
        tick(); tick();
        n_assert++;
        if (tx_par_bit !== 1'b1) begin
            n_fail++; $display("FAIL tx_len15_full: got %b expected 1", tx_par_bit);
        end
    endtask

    task automatic test_rx_basic();
        DATA_LEN = 4'd8; PAR_EN = 1'b1; PAR_MODE = 2'b00;
        rx_frame(16'h0053, 8, 1'b0);
        n_assert++;
        if (rx_par_done !== 1'b0) begin
            n_fail++; $display("FAIL rx_latency_early: got done=%b expected 0", rx_par_done);
        end
        tick();
        n_assert++;
        if (rx_par_done !== 1'b1 || rx_par_err !== 1'b0) begin
            n_fail++; $display("FAIL rx_even_ok: got done=%b err=%b expected done=1 err=0", rx_par_done, rx_par_err);
        end
        tick();
        n_assert++;
        if (rx_par_done !== 1'b0 || err_cnt !== 2'd0) begin
            n_fail++; $display("FAIL rx_done_pulse: got done=%b cnt=%0d expected done=0 cnt=0", rx_par_done, err_cnt);
        end
        rx_frame(16'h0053, 8, 1'b1);
        tick();
        n_assert++;
        if (rx_par_done !== 1'b1 || rx_par_err !== 1'b1) begin
            n_fail++; $display("FAIL rx_even_bad: got done=%b err=%b expected done=1 err=1", rx_par_done, rx_par_err);
        end
        tick();
        n_assert++;
        if (rx_par_err !== 1'b0 || err_cnt !== 2'd1) begin
            n_fail++; $display("FAIL rx_err_cnt1: got err=%b cnt=%0d expected err=0 cnt=1", rx_par_err, err_cnt);
        end
        PAR_MODE = 2'b01;
        rx_frame(16'h0053, 8, 1'b1);
        tick();
        n_assert++;
        if (rx_par_done !== 1'b1 || rx_par_err !== 1'b0) begin
            n_fail++; $display("FAIL rx_odd_ok: got done=%b err=%b expected done=1 err=0", rx_par_done, rx_par_err);
        end
        tick();
        PAR_MODE = 2'b00;
    endtask

    task automatic test_rx_len();
        rx_frame(16'h0053, 7, 1'b0);
        tick();
        n_assert++;
        if (rx_par_err !== 1'b1) begin
            n_fail++; $display("FAIL rx_short: got err=%b expected 1", rx_par_err);
        end
        tick();
        rx_frame(16'h0053, 9, 1'b0);
        tick();
        n_assert++;
        if (rx_par_err !== 1'b1) begin
            n_fail++; $display("FAIL rx_overrun: got err=%b expected 1", rx_par_err);
        end
        tick();
        n_assert++;
        if (err_cnt !== 2'd3) begin
            n_fail++; $display("FAIL rx_err_cnt3: got %0d expected 3", err_cnt);
        end
        // abandoned partial frame, then a clean frame
        rx_start = 1'b1; tick(); rx_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_bit_en = 1'b1; rx_bit = 1'b1; tick();
        end
        rx_bit_en = 1'b0;
        rx_frame(16'h0053, 8, 1'b0);
        tick();
        n_assert++;
        if (rx_par_done !== 1'b1 || rx_par_err !== 1'b0) begin
            n_fail++; $display("FAIL rx_restart: got done=%b err=%b expected done=1 err=0", rx_par_done, rx_par_err);
        end
        tick();
        // rx_start with a data bit: bit discarded; rx_par_en with rx_bit_en: parity only
        rx_start = 1'b1; rx_bit_en = 1'b1; rx_bit = 1'b1; tick(); rx_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx_bit = (i == 0 || i == 1 || i == 4 || i == 6); tick();
        end
        rx_par_en = 1'b1; rx_bit = 1'b0; tick();
        rx_par_en = 1'b0; rx_bit_en = 1'b0;
        tick();
        n_assert++;
        if (rx_par_done !== 1'b1 || rx_par_err !== 1'b0) begin
            n_fail++; $display("FAIL rx_priority: got done=%b err=%b expected done=1 err=0", rx_par_done, rx_par_err);
        end
        tick();
        // rx_par_en in idle is ignored
        rx_par_en = 1'b1; tick(); rx_par_en = 1'b0; tick();
        n_assert++;
        if (rx_par_done !== 1'b0) begin
            n_fail++; $display("FAIL rx_idle_par: got done=%b expected 0", rx_par_done);
        end
    endtask

    task automatic test_err_cnt();
        err_cnt_clr = 1'b1; tick(); err_cnt_clr = 1'b0;
        n_assert++;
        if (err_cnt !== 2'd0) begin
            n_fail++; $display("FAIL cnt_clear: got %0d expected 0", err_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            rx_frame(16'h0053, 8, 1'b1);
            tick(); tick();
        end
        n_assert++;
        if (err_cnt !== 2'd3) begin
            n_fail++; $display("FAIL cnt_saturate: got %0d expected 3", err_cnt);
        end
        rx_frame(16'h0053, 8, 1'b1);
        tick();
        err_cnt_clr = 1'b1; tick(); err_cnt_clr = 1'b0;
        n_assert++;
        if (err_cnt !== 2'd0) begin
            n_fail++; $display("FAIL cnt_clr_wins: got %0d expected 0", err_cnt);
        end
    endtask

    task automatic test_reset_mid_rx();
        rx_frame(16'h0053, 8, 1'b1);
        tick(); tick();
        tx_capture(8'h00, 4'd8, 1'b1, 2'b10);
        tick(); tick();
        rx_start = 1'b1; tick(); rx_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_bit_en = 1'b1; rx_bit = 1'b1; tick();
        end
        rx_bit_en = 1'b0;
        RST = 1'b0;
        #1;
        n_assert++;
        if ({tx_par_bit, tx_par_vld, rx_par_done, rx_par_err, err_cnt} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_rx: got %b expected 000000",
                     {tx_par_bit, tx_par_vld, rx_par_done, rx_par_err, err_cnt});
        end
        tick();
        RST = 1'b1;
        rx_par_en = 1'b1; tick(); rx_par_en = 1'b0;
        tick();
        n_assert++;
        if (rx_par_done !== 1'b0 || rx_par_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_aborts_frame: got done=%b err=%b expected 0 0", rx_par_done, rx_par_err);
        end
    endtask

    initial begin
        test_reset();
        test_tx_even_odd();
        test_tx_len_busy();
        test_tx_modes();
        test_rx_basic();
        test_rx_len();
        test_err_cnt();
        test_reset_mid_rx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_unit.md
Name: parity_unit

Overview:
- Parametrised parity engine for the UART, shared by the Tx and Rx paths.
- Tx side: latches a data word on a valid handshake and produces a registered parity bit.
  - Parity mode, enable and character length are selected at runtime.
- Rx side: accumulates parity over serially received data bits, checks the received parity bit, and flags errors.
  - Maintains a saturating error counter.

Parameters:
- DATA_WD, 8, maximum character width in bits (≥ 2).
- ERR_CNT_WD, 8, width of the saturating Rx parity-error counter.
- LEN_WD, $clog2(DATA_WD+1), width of DATA_LEN (derived; do not override).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- P_DATA  in  DATA_WD  Tx data word, LSB-aligned.
- Data_Valid  in  1  Tx data valid.
- busy  in  1  Tx serializer busy; blocks capture.
- PAR_EN  in  1  parity enable.
- PAR_MODE  in  2  00 even, 01 odd, 10 mark (1), 11 space (0).
- DATA_LEN  in  LEN_WD  active character bits; 0 or > DATA_WD is treated as DATA_WD.
- tx_par_bit  out  1  Tx parity bit.
- tx_par_vld  out  1  tx_par_bit valid for the current captured word.
- rx_start  in  1  start of Rx frame; clears the accumulator.
- rx_bit  in  1  Rx sampled bit value.
- rx_bit_en  in  1  rx_bit is a data bit.
- rx_par_en  in  1  rx_bit is the parity bit.
- rx_par_done  out  1  one-cycle pulse: check complete.
- rx_par_err  out  1  one-cycle pulse: parity or length error.
- err_cnt  out  ERR_CNT_WD  saturating error count.
- err_cnt_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset: all registers and outputs are 0; both FSMs return to IDLE. Reset mid-frame aborts with no done/err pulse.
- Tx capture: occurs on an edge where Data_Valid && !busy.
  - Stores P_DATA masked to the effective DATA_LEN (bits at and above the length are forced to 0).
  - Stores PAR_EN and PAR_MODE.
  - Input changes after capture do not affect the result.
- Tx FSM: T_IDLE → T_CALC on capture; T_CALC → T_HOLD on the next edge.
  - In T_CALC, tx_par_bit is registered:
    - even: ^data
    - odd: ~^data
    - mark: 1
    - space: 0
    - PAR_EN=0: forced to 0
  - Latency: tx_par_bit and tx_par_vld become valid 2 edges after the capture edge.
  - tx_par_vld = 1 only in T_HOLD.
  - A new capture from T_HOLD or T_CALC drops tx_par_vld and restarts at T_CALC.
  - tx_par_bit holds its value until recomputed.
- Rx configuration (PAR_EN, PAR_MODE, effective DATA_LEN) is sampled on rx_start.
- Rx FSM: R_IDLE → R_ACC on rx_start.
  - On entry: acc=0, cnt=0.
  - In R_ACC, rx_bit_en: acc ^= rx_bit, and cnt increments only while cnt < length.
  - Extra bits beyond the length set an overrun flag; they are not accumulated.
- R_ACC + rx_par_en → R_CHK.
  - Expected parity is computed from acc and the sampled mode, using the same table as Tx.
  - err = (PAR_EN && rx_bit ≠ expected) || cnt ≠ length || overrun.
- R_CHK: asserts rx_par_done for 1 cycle, and rx_par_err for 1 cycle if err; then returns to R_IDLE.
  - Rx check latency: 1 edge after the rx_par_en edge.
- Rx boundary rules:
  - rx_par_en or rx_bit_en in R_IDLE: ignored.
  - rx_start in R_ACC or R_CHK: restarts (R_CHK still emits its pulses this cycle).
  - Simultaneous events:
    - rx_start wins over rx_bit_en and rx_par_en; that bit is discarded.
    - rx_par_en wins over rx_bit_en; the bit is treated as the parity bit only.
- err_cnt:
  - Increments by 1 in the cycle rx_par_err is asserted.
  - Saturates at all-ones.
  - err_cnt_clr clears to 0; clr wins over a simultaneous increment.
- Tx and Rx paths are fully independent and may operate concurrently.

Test Plan:
1. DATA_LEN=8, PAR_EN=1, mode even, P_DATA=0xA5, Data_Valid 1 cycle, busy=0 → tx_par_bit=0, tx_par_vld=1 two edges later; repeat with mode odd → tx_par_bit=1.
2. DATA_LEN=7, mode even, P_DATA=0xA5 (masked to 0x25, 3 ones) → tx_par_bit=1; with busy=1 during Data_Valid → no capture, tx_par_vld stays 0; change PAR_MODE after capture → result unchanged.
3. Mark and space modes with P_DATA=0x00 → tx_par_bit=1 and 0 respectively; PAR_EN=0 → tx_par_bit=0.
4. Rx: rx_start, 8 bits of 0x53 (LSB first), parity bit 0, even mode → rx_par_done pulse, rx_par_err=0; repeat with parity bit 1 → rx_par_err pulse, err_cnt=1.
5. Rx length faults with DATA_LEN=8: 7 data bits then parity → rx_par_err; 9 data bits → rx_par_err (overrun); rx_start mid-frame → accumulator cleared, new frame of 0x53 with parity 0 checks clean.
6. ERR_CNT_WD=2: 4 erroring frames → err_cnt=3 (saturated); err_cnt_clr coinciding with an rx_par_err → err_cnt=0; assert RST mid-Rx frame → no pulses, all outputs 0.
